match_sequencer: RTL

- Match-level controller that sequences the ball datapath through one Pong match: wait for start, serve delay, rally, point scoring, game over.
- Sits between the input/UI logic and the ball motion logic.
- Gates ball motion (ball_run), requests ball re-centring (ball_center) and serve direction.
- Keeps both scores and the winner flag for the score/text overlay.

---
 rtl/match_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/match_sequencer.sv
// Match-level Pong sequencer: start, serve delay, rally, scoring and game over.
// Optional pause support is enabled with `define MATCH_SEQUENCER_PAUSE_EN.
module match_sequencer #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start_btn,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef MATCH_SEQUENCER_PAUSE_EN
  input  logic               pause_btn,
`endif
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner_left,
  output logic [2:0]         state_o
);

  localparam int CNT_W = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_RALLY = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;

  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SCORE_W-1:0] score_left_reg, score_left_next;
  logic [SCORE_W-1:0] score_right_reg, score_right_next;
  logic               serve_right_reg, serve_right_next;
  logic               game_over_reg, game_over_next;
  logic               winner_left_reg, winner_left_next;
  logic               ball_center_reg, ball_center_next;
  logic               ball_run_reg;
  logic               start_d_reg;
  logic               start_rise;
  logic               pause_rise;
  logic               win_reached;

  // Edge registers reset to 1 so a button held through reset is not seen as a press.
  assign start_rise  = start_btn & ~start_d_reg;
  assign win_reached = (score_left_reg == WIN_VAL) || (score_right_reg == WIN_VAL);

`ifdef MATCH_SEQUENCER_PAUSE_EN
  logic pause_d_reg;
  assign pause_rise = pause_btn & ~pause_d_reg;
  always_ff @(posedge clk) begin
    if (rst) pause_d_reg <= 1'b1;
    else     pause_d_reg <= pause_btn;
  end
`else
  assign pause_rise = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      serve_right_reg <= 1'b1;
      game_over_reg   <= 1'b0;
      winner_left_reg <= 1'b0;
      ball_center_reg <= 1'b0;
      ball_run_reg    <= 1'b0;
      start_d_reg     <= 1'b1;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      serve_right_reg <= serve_right_next;
      game_over_reg   <= game_over_next;
      winner_left_reg <= winner_left_next;
      ball_center_reg <= ball_center_next;
      ball_run_reg    <= (state_next == S_RALLY);
      start_d_reg     <= start_btn;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_rise) state_next = S_SERVE;
      S_SERVE: if (timing_tick && cnt_reg == '0) state_next = S_RALLY;
      S_RALLY: begin
        if (pause_rise)                   state_next = S_PAUSE;
        else if (miss_left || miss_right) state_next = S_POINT;
      end
      S_POINT: state_next = win_reached ? S_OVER : S_SERVE;
      S_OVER:  if (start_rise) state_next = S_SERVE;
      S_PAUSE: if (pause_rise) state_next = S_RALLY;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_next         = cnt_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    serve_right_next = serve_right_reg;
    game_over_next   = game_over_reg;
    winner_left_next = winner_left_reg;
    ball_center_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_rise) begin
          cnt_next         = SERVE_LOAD;
          ball_center_next = 1'b1;
        end
      end
      S_SERVE: begin
        if (timing_tick && cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
      end
      S_RALLY: begin
        // miss_left has priority when both sides report a miss together.
        if (!pause_rise && miss_left) begin
          if (score_right_reg < WIN_VAL) score_right_next = score_right_reg + 1'b1;
          serve_right_next = 1'b0;
        end else if (!pause_rise && miss_right) begin
          if (score_left_reg < WIN_VAL) score_left_next = score_left_reg + 1'b1;
          serve_right_next = 1'b1;
        end
      end
      S_POINT: begin
        if (win_reached) begin
          game_over_next   = 1'b1;
          winner_left_next = (score_left_reg == WIN_VAL);
        end else begin
          cnt_next         = SERVE_LOAD;
          ball_center_next = 1'b1;
        end
      end
      S_OVER: begin
        if (start_rise) begin
          score_left_next  = '0;
          score_right_next = '0;
          game_over_next   = 1'b0;
          serve_right_next = 1'b1;
          cnt_next         = SERVE_LOAD;
          ball_center_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ball_run    = ball_run_reg;
  assign ball_center = ball_center_reg;
  assign serve_right = serve_right_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;
  assign game_over   = game_over_reg;
  assign winner_left = winner_left_reg;
  assign state_o     = state_reg;

endmodule
